// File: rtl/aes_pkg.sv
// Shared AES definitions: round count, FSM states, byte indexing and GF(2^8) helpers.
package aes_pkg;

  localparam int unsigned AES_NR = 10;
  localparam int unsigned BLK_W  = 128;
  localparam int unsigned RC_W   = 4;

  typedef enum logic [1:0] {
    IDLE,
    ROUND,
    DONE
  } fsm_e;

  // Column-major byte position of (col,row) within a block.
  function automatic int unsigned idx(input int unsigned col, input int unsigned row);
    return 4 * col + row;
  endfunction

  // Multiply by x modulo 0x11b.
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // General GF(2^8) multiply, shift-and-add over xtime.
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] acc;
    logic [7:0] x;
    acc = '0;
    x   = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) acc = acc ^ x;
      x = xtime(x);
    end
    return acc;
  endfunction

  // InvMixColumns row-0 coefficients; row r uses them rotated right by r.
  localparam logic [7:0] IMC_COEF [4] = '{8'h0e, 8'h0b, 8'h0d, 8'h09};

  localparam logic [7:0] INV_SBOX [256] = '{
    8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
    8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
    8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
    8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
    8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
    8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
    8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
    8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
    8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
    8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
    8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
    8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
    8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
    8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
    8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
    8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
  };

endpackage

// File: rtl/aes_inv_round.sv
// One combinational AES inverse round; InvMixColumns bypassed when last is set.
module aes_inv_round
  import aes_pkg::*;
(
  input  logic [BLK_W-1:0] blk_in,
  input  logic [BLK_W-1:0] rk,
  input  logic             last,
  output logic [BLK_W-1:0] blk_out_c
);

  logic [7:0] ark_b [16];
  logic [7:0] mix_acc;

  // InvShiftRows (row r rotated right by r), InvSubBytes, then AddRoundKey
  always_comb begin
    ark_b = '{default: '0};
    for (int unsigned c = 0; c < 4; c++) begin
      for (int unsigned r = 0; r < 4; r++) begin
        ark_b[4'(idx(c, r))] = INV_SBOX[blk_in[7'(8 * idx((c + 4 - r) % 4, r)) +: 8]]
                               ^ rk[7'(8 * idx(c, r)) +: 8];
      end
    end
  end

  // InvMixColumns per column, or straight pass-through in the final round
  always_comb begin
    blk_out_c = '0;
    mix_acc   = '0;
    for (int unsigned c = 0; c < 4; c++) begin
      for (int unsigned r = 0; r < 4; r++) begin
        mix_acc = '0;
        for (int unsigned k = 0; k < 4; k++) begin
          mix_acc = mix_acc ^ gf_mul(ark_b[4'(idx(c, k))], IMC_COEF[2'((k + 4 - r) % 4)]);
        end
        blk_out_c[7'(8 * idx(c, r)) +: 8] = last ? ark_b[4'(idx(c, r))] : mix_acc;
      end
    end
  end

endmodule

// File: rtl/aes_decrypt_core.sv
// Iterative AES-128 inverse cipher, one inverse round per clock.
module aes_decrypt_core
  import aes_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [BLK_W-1:0] in_block,
  output logic [RC_W-1:0]  rk_idx,
  input  logic [BLK_W-1:0] rk,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [BLK_W-1:0] out_block,
  output logic             busy
);

  fsm_e             fsm_q, fsm_d;
  logic [RC_W-1:0]  rc_q, rc_d;
  logic [BLK_W-1:0] data_q, data_d;
  logic [BLK_W-1:0] round_out_c;
  logic             last_c;

  assign last_c = (rc_q == '0);

  aes_inv_round u_round (
    .blk_in    (data_q),
    .rk        (rk),
    .last      (last_c),
    .blk_out_c (round_out_c)
  );

  // State, round counter and datapath register; synchronous reset drops any block in flight
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fsm_q  <= IDLE;
      rc_q   <= '0;
      data_q <= '0;
    end else begin
      fsm_q  <= fsm_d;
      rc_q   <= rc_d;
      data_q <= data_d;
    end
  end

  // Next-state logic and outputs decoded from registered state
  always_comb begin
    fsm_d     = fsm_q;
    rc_d      = rc_q;
    data_d    = data_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    rk_idx    = RC_W'(AES_NR);
    out_block = '0;
    case (fsm_q)
      IDLE: begin
        // rst_n gating keeps in_ready low during reset; acceptance itself is overridden by the reset flop
        in_ready = rst_n;
        if (in_valid) begin
          data_d = in_block ^ rk;
          rc_d   = RC_W'(AES_NR - 1);
          fsm_d  = ROUND;
        end
      end
      ROUND: begin
        busy   = 1'b1;
        rk_idx = rc_q;
        data_d = round_out_c;
        if (last_c) begin
          fsm_d = DONE;
        end else begin
          rc_d = rc_q - RC_W'(1);
        end
      end
      DONE: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        rk_idx    = '0;
        out_block = data_q;
        if (out_ready) fsm_d = IDLE;
      end
      default: fsm_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_aes_decrypt_core.sv
// Directed and randomized checks for aes_decrypt_core against an independent AES encryption model.
module tb_aes_decrypt_core;

  typedef logic [127:0] blk_t;

  typedef struct {
    blk_t key;
    blk_t ct;
    blk_t pt;
    int   stall;
  } vec_t;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  blk_t       in_block;
  logic [3:0] rk_idx;
  blk_t       rk;
  logic       out_valid;
  logic       out_ready;
  blk_t       out_block;
  logic       busy;

  blk_t       rk_tab [16];
  logic [7:0] sbox [256];
  int         n_checks;
  int         n_errors;

  aes_decrypt_core dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_block  (in_block),
    .rk_idx    (rk_idx),
    .rk        (rk),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_block (out_block),
    .busy      (busy)
  );

  // Key store returns the round key for the requested index in the same cycle
  assign rk = rk_tab[rk_idx];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string name, input blk_t act, input blk_t exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // FIPS hex string order (first byte leftmost) to column-major bus order
  function automatic blk_t fh(input blk_t h);
    blk_t r;
    for (int i = 0; i < 16; i++) r[8*i +: 8] = h[8*(15-i) +: 8];
    return r;
  endfunction

  // Forward S-box from multiplicative inverse plus affine transform
  task automatic build_sbox();
    logic [7:0] inv;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++) if (gm(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      sbox[x] = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                    ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    end
  endtask

  task automatic set_key(input blk_t key);
    logic [7:0] eb [176];
    logic [7:0] t [4];
    logic [7:0] rc;
    logic [7:0] tmp;
    for (int i = 0; i < 16; i++) eb[i] = key[8*i +: 8];
    rc = 8'h01;
    for (int i = 16; i < 176; i += 4) begin
      for (int j = 0; j < 4; j++) t[j] = eb[i-4+j];
      if (i % 16 == 0) begin
        tmp  = t[0];
        t[0] = sbox[t[1]] ^ rc;
        t[1] = sbox[t[2]];
        t[2] = sbox[t[3]];
        t[3] = sbox[tmp];
        rc   = gm(rc, 8'h02);
      end
      for (int j = 0; j < 4; j++) eb[i+j] = eb[i-16+j] ^ t[j];
    end
    for (int r = 0; r < 16; r++) rk_tab[r] = '0;
    for (int r = 0; r < 11; r++)
      for (int i = 0; i < 16; i++) rk_tab[r][8*i +: 8] = eb[16*r+i];
  endtask

  // Forward cipher with the current key schedule
  function automatic blk_t encrypt(input blk_t pt);
    logic [7:0] s [16];
    logic [7:0] t [16];
    logic [7:0] a0, a1, a2, a3;
    blk_t res;
    for (int i = 0; i < 16; i++) s[i] = pt[8*i +: 8] ^ rk_tab[0][8*i +: 8];
    for (int r = 1; r <= 10; r++) begin
      for (int c = 0; c < 4; c++)
        for (int w = 0; w < 4; w++) t[4*c+w] = sbox[s[4*((c+w)%4)+w]];
      for (int c = 0; c < 4; c++) begin
        a0 = t[4*c]; a1 = t[4*c+1]; a2 = t[4*c+2]; a3 = t[4*c+3];
        if (r < 10) begin
          s[4*c]   = gm(a0, 8'h02) ^ gm(a1, 8'h03) ^ a2 ^ a3;
          s[4*c+1] = a0 ^ gm(a1, 8'h02) ^ gm(a2, 8'h03) ^ a3;
          s[4*c+2] = a0 ^ a1 ^ gm(a2, 8'h02) ^ gm(a3, 8'h03);
          s[4*c+3] = gm(a0, 8'h03) ^ a1 ^ a2 ^ gm(a3, 8'h02);
        end else begin
          s[4*c] = a0; s[4*c+1] = a1; s[4*c+2] = a2; s[4*c+3] = a3;
        end
      end
      for (int i = 0; i < 16; i++) s[i] = s[i] ^ rk_tab[r][8*i +: 8];
    end
    for (int i = 0; i < 16; i++) res[8*i +: 8] = s[i];
    return res;
  endfunction

  // One full block: accept, rk_idx walk, latency, result, hold under stall, release
  task automatic run_block(input string tag, input blk_t ct, input blk_t pt, input int stall);
    int   n;
    int   cnt;
    int   vc;
    bit   seq_ok;
    bit   hold_ok;
    blk_t hold;
    out_ready = (stall == 0);
    in_block  = ct;
    in_valid  = 1'b1;
    n = 0;
    while (!in_ready && n < 40) begin
      @(negedge clk);
      n++;
    end
    check({tag, " accept"}, in_ready, 1);
    check({tag, " idle rk_idx"}, rk_idx, 10);
    @(negedge clk);
    in_valid = 1'b0;
    in_block = '0;
    cnt    = 0;
    seq_ok = 1'b1;
    while (!out_valid && cnt < 30) begin
      if (rk_idx !== 4'(9 - cnt)) seq_ok = 1'b0;
      @(negedge clk);
      cnt++;
    end
    check({tag, " latency"}, cnt, 10);
    check({tag, " rk_idx sequence"}, seq_ok, 1);
    check({tag, " plaintext"}, out_block, pt);
    check({tag, " done rk_idx"}, rk_idx, 0);
    hold    = out_block;
    hold_ok = 1'b1;
    vc      = 0;
    while (out_valid && vc < stall + 5) begin
      vc++;
      if (out_block !== hold || in_ready !== 1'b0) hold_ok = 1'b0;
      if (vc > stall) begin
        out_ready = 1'b1;
        in_valid  = 1'b0;
      end else begin
        in_valid = vc[0];
        in_block = {$urandom, $urandom, $urandom, $urandom};
      end
      @(negedge clk);
    end
    check({tag, " valid cycles"}, vc, stall + 1);
    check({tag, " hold stable"}, hold_ok, 1);
    check({tag, " in_ready after"}, in_ready, 1);
    check({tag, " busy after"}, busy, 0);
    in_valid = 1'b0;
  endtask

  initial begin
    vec_t vecs [4];
    blk_t ct1, pt1, ct2, pt2, key, pt;
    blk_t outs [2];
    int   acc [2];
    int   na, no, n, stall;
    bit   saw;

    n_checks = 0;
    n_errors = 0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    in_block  = '0;
    build_sbox();
    set_key('0);

    vecs[0] = '{fh(128'h000102030405060708090a0b0c0d0e0f), fh(128'h69c4e0d86a7b0430d8cdb78070b4c55a),
                fh(128'h00112233445566778899aabbccddeeff), 0};
    vecs[1] = '{fh(128'h2b7e151628aed2a6abf7158809cf4f3c), fh(128'h3925841d02dc09fbdc118597196a0b32),
                fh(128'h3243f6a8885a308d313198a2e0370734), 0};
    vecs[2] = '{128'h0, fh(128'h66e94bd4ef8a2c3b884cfa59ca342b2e), 128'h0, 2};
    vecs[3] = '{fh(128'h2b7e151628aed2a6abf7158809cf4f3c), fh(128'h3925841d02dc09fbdc118597196a0b32),
                fh(128'h3243f6a8885a308d313198a2e0370734), 5};

    // Reset values
    repeat (3) @(negedge clk);
    check("reset in_ready", in_ready, 0);
    check("reset out_valid", out_valid, 0);
    check("reset busy", busy, 0);
    check("reset rk_idx", rk_idx, 10);
    check("reset out_block", out_block, 0);
    rst_n = 1'b1;
    #1;
    check("release in_ready", in_ready, 1);

    // Reference key schedule sanity against the published last round key
    set_key(fh(128'h2b7e151628aed2a6abf7158809cf4f3c));
    check("model rk10", rk_tab[10], fh(128'hd014f9a8c9ee2589e13f0cc8b6630ca6));

    // Directed vectors, including backpressure stalls
    for (int i = 0; i < 4; i++) begin
      set_key(vecs[i].key);
      check($sformatf("vec%0d model", i), encrypt(vecs[i].pt), vecs[i].ct);
      run_block($sformatf("vec%0d", i), vecs[i].ct, vecs[i].pt, vecs[i].stall);
    end

    // Back-to-back blocks with in_valid and out_ready held high
    set_key(fh(128'h2b7e151628aed2a6abf7158809cf4f3c));
    ct1 = fh(128'h3925841d02dc09fbdc118597196a0b32);
    pt1 = fh(128'h3243f6a8885a308d313198a2e0370734);
    pt2 = 128'hdeadbeef_01234567_89abcdef_55aa33cc;
    ct2 = encrypt(pt2);
    na = 0;
    no = 0;
    acc[0] = 0; acc[1] = 0;
    outs[0] = '0; outs[1] = '0;
    out_ready = 1'b1;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (out_valid) begin
        if (no < 2) outs[no] = out_block;
        no++;
      end
      in_block = (na >= 1) ? ct2 : ct1;
      in_valid = (na < 2);
      if (in_ready && in_valid) begin
        acc[na] = k;
        na++;
      end
    end
    in_valid = 1'b0;
    check("b2b accept count", na, 2);
    check("b2b accept spacing", acc[1] - acc[0], 12);
    check("b2b output count", no, 2);
    check("b2b plaintext 1", outs[0], pt1);
    check("b2b plaintext 2", outs[1], pt2);

    // Reset in the middle of a block
    set_key(fh(128'h000102030405060708090a0b0c0d0e0f));
    in_block = fh(128'h3925841d02dc09fbdc118597196a0b32);
    in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 40) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    in_valid = 1'b0;
    n   = 0;
    saw = 1'b0;
    while (rk_idx !== 4'd5 && n < 20) begin
      if (out_valid) saw = 1'b1;
      @(negedge clk);
      n++;
    end
    check("midreset reached round 5", rk_idx, 5);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("midreset in_ready", in_ready, 1);
    check("midreset out_valid", out_valid, 0);
    check("midreset busy", busy, 0);
    check("midreset rk_idx", rk_idx, 10);
    check("midreset out_block", out_block, 0);
    for (int k = 0; k < 15; k++) begin
      @(negedge clk);
      if (out_valid) saw = 1'b1;
    end
    check("midreset aborted block emitted", saw, 0);
    run_block("c1 after reset", vecs[0].ct, vecs[0].pt, 0);

    // Random keys and plaintexts with occasional output stalls
    for (int i = 0; i < 1000; i++) begin
      key = {$urandom, $urandom, $urandom, $urandom};
      pt  = {$urandom, $urandom, $urandom, $urandom};
      set_key(key);
      stall = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 4)) : 0;
      run_block($sformatf("rand%0d", i), encrypt(pt), pt, stall);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
